// File: rtl/ipbase_arbit_rr_pktlock.sv
// Packet-level round-robin arbiter and stream mux: NUM sources share one sink,
// a granted source keeps the output until its last beat is accepted.
module ipbase_arbit_rr_pktlock #(
   parameter int NUM = 4,
   parameter int DW  = 64,
   parameter int SW  = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM-1:0]    s_valid,
   input  logic [NUM-1:0]    s_last,
   input  logic [NUM*DW-1:0] s_data,
   output logic [NUM-1:0]    s_ready,
   output logic              m_valid,
   output logic              m_last,
   output logic [DW-1:0]     m_data,
   output logic [SW-1:0]     m_src,
   input  logic              m_ready,
   output logic              busy
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [NUM-1:0] prio_q, prio_d;
   logic [NUM-1:0] gnt_q, gnt_d;
   logic [SW-1:0]  src_q, src_d;
   logic [NUM-1:0] gnt;
   logic [SW-1:0]  gntIdx;
   logic           found;
   logic           selValid;
   logic           selLast;
   logic [DW-1:0]  selData;

   // Circular first-requester search: offset j outer so the nearest requester
   // at or after the prio position wins; prio is one-hot so only one i matches.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int j = 0; j < NUM; j++) begin
         for (int i = 0; i < NUM; i++) begin
            if (!found && prio_q[i] && s_valid[(i + j) % NUM]) begin
               gnt[(i + j) % NUM] = 1'b1;
               found              = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gntIdx = '0;
      for (int i = 0; i < NUM; i++) begin
         if (gnt[i]) begin
            gntIdx = SW'(i);
         end
      end
   end

   always_comb begin
      selValid = 1'b0;
      selLast  = 1'b0;
      selData  = '0;
      for (int i = 0; i < NUM; i++) begin
         if (src_q == SW'(i)) begin
            selValid = s_valid[i];
            selLast  = s_last[i];
            selData  = s_data[i*DW +: DW];
         end
      end
   end

   // Outputs are a pure pass-through of the locked source; release on its
   // accepted last beat rotates priority to just past the winner.
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      gnt_d   = gnt_q;
      src_d   = src_q;
      s_ready = '0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_data  = '0;
      case (state_q)
         IDLE: begin
            if (|s_valid) begin
               gnt_d   = gnt;
               src_d   = gntIdx;
               state_d = LOCK;
            end
         end
         LOCK: begin
            m_valid = selValid;
            m_last  = selLast;
            m_data  = selData;
            s_ready = gnt_q & {NUM{m_ready}};
            if (selValid && m_ready && selLast) begin
               prio_d  = {gnt_q[NUM-2:0], gnt_q[NUM-1]};
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= {{(NUM-1){1'b0}}, 1'b1};
         gnt_q   <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         gnt_q   <= gnt_d;
         src_q   <= src_d;
      end
   end

   assign m_src = src_q;
   assign busy  = (state_q == LOCK);

   aReadyOneHot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(s_ready));
   aPrioOneHot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot(prio_q));
   aGntState:     assert property (@(posedge clk) disable iff (!rst_n)
                                   ((state_q == LOCK) ? $onehot(gnt_q) : (gnt_q == '0)));

endmodule

// File: tb/tb_ipbase_arbit_rr_pktlock.sv
// Self-checking bench for ipbase_arbit_rr_pktlock: vector table, corner-case
// sequences and randomized traffic against a packet-level reference model.
module tb_ipbase_arbit_rr_pktlock;

   localparam int NUM = 4;
   localparam int DW  = 64;
   localparam int SW  = 2;

   logic              clk;
   logic              rst_n;
   logic [NUM-1:0]    s_valid;
   logic [NUM-1:0]    s_last;
   logic [NUM*DW-1:0] s_data;
   logic [NUM-1:0]    s_ready;
   logic              m_valid;
   logic              m_last;
   logic [DW-1:0]     m_data;
   logic [SW-1:0]     m_src;
   logic              m_ready;
   logic              busy;

   ipbase_arbit_rr_pktlock #(.NUM(NUM), .DW(DW), .SW(SW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_data  (s_data),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_last  (m_last),
      .m_data  (m_data),
      .m_src   (m_src),
      .m_ready (m_ready),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         rstn;
      logic [3:0] v;
      logic [3:0] l;
      bit         mr;
      bit         eBusy;
      logic [3:0] eReady;
      bit         eValid;
      bit         eLast;
      logic [1:0] eSrc;
   } vec_t;

   int nChecks = 0;
   int nFail   = 0;

   // Reference model: which source owns the output and where the search starts
   bit             mdlLocked;
   int             mdlOwner;
   int             mdlPrio;
   int             mdlSrc;
   bit             expBusy;
   bit             expValid;
   bit             expLast;
   logic [NUM-1:0] expReady;
   logic [DW-1:0]  expData;
   int             expSrc;

   task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mdlLocked = 1'b0;
      mdlOwner  = 0;
      mdlPrio   = 0;
      mdlSrc    = 0;
   endtask

   task automatic modelPredict();
      expBusy  = mdlLocked;
      expSrc   = mdlSrc;
      expReady = '0;
      expValid = 1'b0;
      expLast  = 1'b0;
      expData  = '0;
      if (mdlLocked) begin
         expValid = s_valid[mdlOwner];
         expLast  = s_last[mdlOwner];
         expData  = s_data[mdlOwner*DW +: DW];
         if (m_ready) expReady[mdlOwner] = 1'b1;
      end
   endtask

   task automatic modelCommit();
      bit got;
      if (!rst_n) begin
         modelReset();
      end else if (mdlLocked) begin
         if (s_valid[mdlOwner] && m_ready && s_last[mdlOwner]) begin
            mdlLocked = 1'b0;
            mdlPrio   = (mdlOwner + 1) % NUM;
         end
      end else if (s_valid != '0) begin
         got = 1'b0;
         for (int j = 0; j < NUM; j++) begin
            if (!got && s_valid[(mdlPrio + j) % NUM]) begin
               mdlOwner = (mdlPrio + j) % NUM;
               got      = 1'b1;
            end
         end
         mdlLocked = 1'b1;
         mdlSrc    = mdlOwner;
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge
   task automatic applyStimulus(bit rstn, logic [NUM-1:0] v, logic [NUM-1:0] l,
                                logic [NUM*DW-1:0] d, bit mr);
      rst_n   = rstn;
      s_valid = v;
      s_last  = l;
      s_data  = d;
      m_ready = mr;
      #4;
      modelPredict();
   endtask

   task automatic checkOutput();
      checkVal("busy", 64'(busy), 64'(expBusy));
      checkVal("s_ready", 64'(s_ready), 64'(expReady));
      checkVal("m_valid", 64'(m_valid), 64'(expValid));
      checkVal("m_src", 64'(m_src), 64'(expSrc));
      if (expValid) begin
         checkVal("m_last", 64'(m_last), 64'(expLast));
         checkVal("m_data", m_data, expData);
      end
      if (!expBusy) checkVal("m_data_idle", m_data, 64'd0);
   endtask

   task automatic finishCycle();
      @(posedge clk);
      modelCommit();
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, '0, '0, '0, 1'b0);
      finishCycle();
   endtask

   function automatic vec_t mkVec(logic [3:0] v, logic [3:0] l, bit eBusy, logic [3:0] eReady,
                                  bit eValid, bit eLast, logic [1:0] eSrc);
      vec_t t;
      t.rstn = 1'b1; t.v = v; t.l = l; t.mr = 1'b1;
      t.eBusy = eBusy; t.eReady = eReady; t.eValid = eValid; t.eLast = eLast; t.eSrc = eSrc;
      return t;
   endfunction

   vec_t              tbl[23];
   logic [NUM*DW-1:0] dd;
   logic [NUM-1:0]    v;
   logic [NUM-1:0]    l;
   bit                mr;
   bit                rstn;
   int                beat;
   int                beat1;
   int                xfers;
   bit                hold;
   logic [DW-1:0]     holdData;
   int                order[$];
   bit                srcActive[NUM];
   int                srcBeat[NUM];
   int                srcLen[NUM];
   logic [DW-1:0]     srcData[NUM];

   initial begin
      rst_n   = 1'b0;
      s_valid = '0;
      s_last  = '0;
      s_data  = '0;
      m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      modelReset();

      // Idle after reset, then a 1010 request pattern with 3-beat packets
      for (int r = 0; r < 10; r++) tbl[r] = mkVec(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
      tbl[10] = mkVec(4'b1010, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
      tbl[11] = mkVec(4'b1010, 4'b0000, 1, 4'b0010, 1, 0, 2'd1);
      tbl[12] = mkVec(4'b1010, 4'b0000, 1, 4'b0010, 1, 0, 2'd1);
      tbl[13] = mkVec(4'b1010, 4'b0010, 1, 4'b0010, 1, 1, 2'd1);
      tbl[14] = mkVec(4'b1000, 4'b0000, 0, 4'b0000, 0, 0, 2'd1);
      tbl[15] = mkVec(4'b1000, 4'b0000, 1, 4'b1000, 1, 0, 2'd3);
      tbl[16] = mkVec(4'b1000, 4'b0000, 1, 4'b1000, 1, 0, 2'd3);
      tbl[17] = mkVec(4'b1000, 4'b1000, 1, 4'b1000, 1, 1, 2'd3);
      tbl[18] = mkVec(4'b0110, 4'b0000, 0, 4'b0000, 0, 0, 2'd3);
      tbl[19] = mkVec(4'b0110, 4'b0010, 1, 4'b0010, 1, 1, 2'd1);
      tbl[20] = mkVec(4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 2'd1);
      tbl[21] = mkVec(4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 2'd2);
      tbl[22] = mkVec(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd2);

      for (int r = 0; r < 23; r++) begin
         for (int i = 0; i < NUM; i++) dd[i*DW +: DW] = {32'(i), 32'(r)};
         applyStimulus(tbl[r].rstn, tbl[r].v, tbl[r].l, dd, tbl[r].mr);
         checkOutput();
         checkVal($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].eBusy));
         checkVal($sformatf("tbl%0d_ready", r), 64'(s_ready), 64'(tbl[r].eReady));
         checkVal($sformatf("tbl%0d_valid", r), 64'(m_valid), 64'(tbl[r].eValid));
         checkVal($sformatf("tbl%0d_src", r), 64'(m_src), 64'(tbl[r].eSrc));
         if (tbl[r].eValid) checkVal($sformatf("tbl%0d_last", r), 64'(m_last), 64'(tbl[r].eLast));
         finishCycle();
      end

      // Wrap-around fairness: everyone sends single-beat packets continuously
      doReset();
      for (int i = 0; i < NUM; i++) dd[i*DW +: DW] = {32'hF000_0000 | 32'(i), 32'h1234};
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b1, 4'b1111, 4'b1111, dd, 1'b1);
         checkOutput();
         if (m_valid && m_ready) order.push_back(int'(m_src));
         finishCycle();
      end
      checkVal("fair_count", 64'(order.size()), 64'd8);
      for (int i = 0; i < order.size() && i < 8; i++)
         checkVal($sformatf("fair_grant%0d", i), 64'(order[i]), 64'(i % NUM));

      // Backpressure on a locked 4-beat packet from src2 while src0 waits
      doReset();
      for (int i = 0; i < NUM; i++) dd[i*DW +: DW] = {32'(i), 32'h0};
      applyStimulus(1'b1, 4'b0100, 4'b0000, dd, 1'b1);
      checkOutput();
      finishCycle();
      beat = 0; xfers = 0; hold = 1'b0; holdData = '0;
      for (int k = 0; k < 10; k++) begin
         v = (beat < 4) ? 4'b0101 : 4'b0001;
         l = '0;
         l[2] = (beat == 3);
         dd[2*DW +: DW] = {32'h2, 32'(beat)};
         dd[0 +: DW]    = {32'h0, 32'hAAAA};
         mr = (k % 2 == 0);
         applyStimulus(1'b1, v, l, dd, mr);
         checkOutput();
         if (beat < 4) checkVal("bp_src0_ready", 64'(s_ready[0]), 64'd0);
         if (hold) checkVal("bp_data_stable", m_data, holdData);
         hold     = m_valid && !m_ready;
         holdData = m_data;
         if (m_valid && m_ready && m_src == 2'd2) xfers++;
         if (expReady[2] && v[2]) beat++;
         finishCycle();
      end
      checkVal("bp_transfers", 64'(xfers), 64'd4);

      // Locked src0 stalls for 3 cycles mid-packet while src1 requests
      doReset();
      for (int i = 0; i < NUM; i++) dd[i*DW +: DW] = {32'(i), 32'h0};
      applyStimulus(1'b1, 4'b0011, 4'b0000, dd, 1'b1);
      checkOutput();
      finishCycle();
      beat = 0; beat1 = 0;
      for (int k = 0; k < 11; k++) begin
         v = '0;
         l = '0;
         v[0] = !(k >= 2 && k <= 4) && beat < 5;
         v[1] = (beat1 == 0);
         l[0] = (beat == 4);
         l[1] = 1'b1;
         dd[0 +: DW]  = {32'h0, 32'(beat)};
         dd[DW +: DW] = {32'h1, 32'h0};
         applyStimulus(1'b1, v, l, dd, 1'b1);
         checkOutput();
         if (k >= 2 && k <= 4) begin
            checkVal("stall_busy", 64'(busy), 64'd1);
            checkVal("stall_valid", 64'(m_valid), 64'd0);
            checkVal("stall_src", 64'(m_src), 64'd0);
            checkVal("stall_src1_ready", 64'(s_ready[1]), 64'd0);
         end
         if (k == 9) begin
            checkVal("stall_src1_grant", 64'(m_src), 64'd1);
            checkVal("stall_src1_ready", 64'(s_ready), 64'b0010);
         end
         if (expReady[0] && v[0]) beat++;
         if (expReady[1] && v[1]) beat1 = 1;
         finishCycle();
      end

      // Reset during beat 2 of a 5-beat packet from src3
      doReset();
      for (int i = 0; i < NUM; i++) dd[i*DW +: DW] = {32'(i), 32'h0};
      applyStimulus(1'b1, 4'b1000, 4'b0000, dd, 1'b1);
      checkOutput();
      finishCycle();
      beat = 0;
      for (int k = 0; k < 8; k++) begin
         rstn = (k != 1);
         v = '0;
         l = '0;
         v[3] = (beat < 5);
         l[3] = (beat == 4);
         dd[3*DW +: DW] = {32'h3, 32'(beat)};
         applyStimulus(rstn, v, l, dd, 1'b1);
         checkOutput();
         if (k == 2) begin
            checkVal("rst_busy", 64'(busy), 64'd0);
            checkVal("rst_ready", 64'(s_ready), 64'd0);
         end
         if (k == 3) begin
            checkVal("rst_regrant_src", 64'(m_src), 64'd3);
            checkVal("rst_restart_data", m_data, {32'h3, 32'd2});
         end
         if (expReady[3] && v[3]) beat++;
         finishCycle();
      end

      // Randomized traffic with occasional resets and random sink backpressure
      doReset();
      for (int i = 0; i < NUM; i++) begin
         srcActive[i] = 1'b0; srcBeat[i] = 0; srcLen[i] = 1; srcData[i] = '0;
      end
      for (int k = 0; k < 400; k++) begin
         v = '0;
         l = '0;
         for (int i = 0; i < NUM; i++) begin
            if (!srcActive[i] && ($urandom % 4 == 0)) begin
               srcActive[i] = 1'b1;
               srcBeat[i]   = 0;
               srcLen[i]    = int'($urandom_range(1, 4));
               srcData[i]   = {$urandom, $urandom};
            end
            v[i] = srcActive[i];
            l[i] = srcActive[i] && (srcBeat[i] == srcLen[i] - 1);
            dd[i*DW +: DW] = srcData[i];
         end
         mr   = ($urandom % 4 != 0);
         rstn = ($urandom % 64 != 0);
         applyStimulus(rstn, v, l, dd, mr);
         checkOutput();
         for (int i = 0; i < NUM; i++) begin
            if (expReady[i] && v[i]) begin
               if (l[i]) srcActive[i] = 1'b0;
               srcBeat[i]++;
               srcData[i] = {$urandom, $urandom};
            end
         end
         finishCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/ipbase_arbit_rr_pktlock.md
Name: ipbase_arbit_rr_pktlock

Overview:
- Packet-level round-robin arbiter and stream mux for NUM stream sources feeding one stream sink.
- Holds the one-hot rotating priority register and the per-packet grant lock.
- The grant comes from a combinational circular first-requester search: the lowest-index requester at or after the prio position, wrapping around.
- The granted source stays locked until its last beat is accepted downstream; then priority rotates past the winner.

Parameters:
- NUM, 4, number of requesting sources (>=2).
- DW, 64, data width per source.
- SW, $clog2(NUM) (min 1), width of the source-index output.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_valid  in  NUM  per-source beat valid
- s_last  in  NUM  per-source last beat of packet
- s_data  in  NUM*DW  per-source data, source i at [i*DW +: DW]
- s_ready  out  NUM  per-source ready; at most one bit set
- m_valid  out  1  output beat valid
- m_last  out  1  output last beat
- m_data  out  DW  output data
- m_src  out  SW  index of the locked source
- m_ready  in  1  sink ready
- busy  out  1  arbiter is in LOCK

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE, prio=NUM'b1 (bit0), gnt_q=0, m_src=0.
  - s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0.
  - Reset mid-packet drops the lock immediately; the partial packet is abandoned, and the block takes no recovery action.
- Grant computation (combinational):
  - gnt = bit of the first set s_valid at index >= position of prio, circularly.
  - gnt = 0 when s_valid = 0.
- IDLE:
  - s_ready=0, m_valid=0.
  - If |s_valid at the edge: gnt_q<=gnt, m_src<=index(gnt), state<=LOCK.
  - Arbitration latency is 1 cycle from request to first possible output beat.
- LOCK:
  - Let k = m_src.
  - m_valid = s_valid[k], m_last = s_last[k], m_data = s_data[k] (combinational pass-through, no register stage).
  - s_ready[k] = m_ready; all other s_ready bits are 0.
  - A beat transfers when s_valid[k] & m_ready.
  - If s_valid[k] deasserts mid-packet: m_valid=0 and the lock is held; no other source can be granted.
- Release:
  - Happens on the transfer with s_last[k]=1.
  - prio <= rotate_left(gnt_q,1); bit NUM-1 wraps to bit0.
  - gnt_q <= 0, state <= IDLE.
- Throughput: one bubble cycle in IDLE between packets; back-to-back re-arbitration is not supported.
- Single-beat packet: valid&last on the first LOCK cycle releases after one beat.
- Requests from non-granted sources are ignored during LOCK. Their s_ready stays 0; they must hold valid (stream rule: valid is not withdrawn before ready).
- prio changes only on release, never on grant and never in IDLE. prio is always one-hot.
- m_data when m_valid=0 is don't-care, but it must be 0 while in IDLE.
- busy = (state==LOCK).
- Assertions:
  - $onehot0(s_ready).
  - $onehot(prio) after reset.
  - gnt_q one-hot in LOCK, zero in IDLE.

Test Plan:
- Reset, then s_valid=4'b0000 for 10 cycles -> busy=0, s_ready=0, m_valid=0, prio=4'b0001 throughout.
- Arbitration and lock:
  - Stimulus: s_valid=4'b1010, 3-beat packets on each, m_ready=1.
  - Required: cycle1 m_src=1; beats on s_ready=4'b0010 for 3 cycles; release, prio=4'b0100.
  - Then IDLE 1 cycle, grant src3, prio after release=4'b0001.
- Wrap-around fairness:
  - Stimulus: all 4 sources continuously sending 1-beat packets.
  - Required: grant order 0,1,2,3,0,1..., each packet followed by one IDLE cycle; 8 packets in 16 cycles.
- Backpressure:
  - Stimulus: src2 locked with a 4-beat packet, m_ready toggling 1,0,1,0...
  - Required: m_data stable while m_valid&!m_ready; exactly 4 transfers; src0 s_ready=0 the whole time even though s_valid[0]=1.
- Source stall:
  - Stimulus: locked src0 drops s_valid for 3 cycles mid-packet, src1 requesting.
  - Required: busy=1, m_valid=0, m_src=0 during the gap; src1 granted only after src0's last beat.
- Reset mid-packet:
  - Stimulus: rst_n=0 for 1 cycle during beat 2 of 5 from src3.
  - Required: next cycle busy=0, s_ready=0, prio=4'b0001.
  - After rst_n=1 with s_valid=4'b1000: src3 re-granted and its packet starts over from the source's beat 3 as presented.
